// File: rtl/jk_step_driver.sv
// Up/down step driver for an external bank of four JK flip-flops.
// Computes J/K excitation from a target value and shadows the bank in q.
module jk_step_driver (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir,
    input  logic       pause,
    input  logic [3:0] limit,
    input  logic       load_valid,
    input  logic [3:0] load_data,
    output logic       load_ready,
    output logic [3:0] j,
    output logic [3:0] k,
    output logic [3:0] q,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] nxt;
    logic [3:0] step_val;

    // State register and shadow of the downstream JK bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= 4'h0;
        end else begin
            state <= state_nxt;
            q     <= nxt;
        end
    end

    // Next-state and target-value selection; holding means nxt == q.
    always_comb begin
        state_nxt = state;
        nxt       = q;
        step_val  = dir ? (q - 4'd1) : (q + 4'd1);
        unique case (state)
            IDLE: begin
                if (load_valid) begin
                    nxt = load_data;
                end else if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!pause) begin
                    nxt = step_val;
                    if (step_val == limit) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Excitation and status outputs; reset forces the bank to clear.
    always_comb begin
        j          = nxt & ~q;
        k          = ~nxt & q;
        load_ready = (state == IDLE);
        busy       = (state == RUN);
        done       = (state == DONE);
        if (rst) begin
            j          = 4'h0;
            k          = 4'hF;
            load_ready = 1'b0;
            busy       = 1'b0;
            done       = 1'b0;
        end
    end

endmodule
